// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and default bus widths.
package axi4_lite_pkg;

  localparam int AXIL_ADDR_W = 4;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R
  } mst_state_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle (no RRESP) with master and slave views.
interface axi4_lite_master_if
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = AXIL_ADDR_W,
  parameter int DATA_W = AXIL_DATA_W
) ();

  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RVALID
  );

endinterface

// File: rtl/axi4_lite_timeout_cnt.sv
// Watchdog cycle counter: counts while enabled, flags expiry at LIMIT cycles and holds there.
module axi4_lite_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // The first busy cycle reads 0, so the LIMIT-th busy cycle reads LIMIT-1.
  assign expired = (r_cnt == CW'(LIMIT - 1));

  always_ff @(posedge ACLK) begin
    if (!ARESETn || clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master turning one-shot user commands into bus transactions.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W         = AXIL_ADDR_W,
  parameter int DATA_W         = AXIL_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              transfer,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        resp,
  axi4_lite_master_if.master bus
);

  mst_state_t        r_state, w_state_next;
  logic              r_awvalid, w_awvalid_next;
  logic              r_wvalid, w_wvalid_next;
  logic              r_arvalid, w_arvalid_next;
  logic              r_aw_done, w_aw_done_next;
  logic              r_w_done, w_w_done_next;
  logic              r_done, w_done_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic [DATA_W-1:0] r_rdata, w_rdata_next;
  logic [1:0]        r_resp, w_resp_next;
  logic              w_busy;
  logic              w_expired;

  assign w_busy = (r_state != ST_IDLE);

`ifdef AXIL_MASTER_TIMEOUT_EN
  axi4_lite_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clear   (!w_busy),
    .enable  (w_busy),
    .expired (w_expired)
  );
`else
  // Watchdog compiled out: the parameter stays referenced but can never fire.
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_state_next   = r_state;
    w_awvalid_next = r_awvalid;
    w_wvalid_next  = r_wvalid;
    w_arvalid_next = r_arvalid;
    w_aw_done_next = r_aw_done;
    w_w_done_next  = r_w_done;
    w_done_next    = 1'b0;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_rdata_next   = r_rdata;
    w_resp_next    = r_resp;

    unique case (r_state)
      ST_IDLE: begin
        if (transfer) begin
          w_addr_next    = addr;
          w_wdata_next   = wdata;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
          if (write) begin
            w_state_next   = ST_WR_AW_W;
            w_awvalid_next = 1'b1;
            w_wvalid_next  = 1'b1;
          end else begin
            w_state_next   = ST_RD_AR;
            w_arvalid_next = 1'b1;
          end
        end
      end
      ST_WR_AW_W: begin
        if (r_awvalid && bus.AWREADY) begin
          w_awvalid_next = 1'b0;
          w_aw_done_next = 1'b1;
        end
        if (r_wvalid && bus.WREADY) begin
          w_wvalid_next = 1'b0;
          w_w_done_next = 1'b1;
        end
        // Flags merged with this edge's handshakes so simultaneous AW/W advance at once.
        if (w_aw_done_next && w_w_done_next) begin
          w_state_next = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (bus.BVALID) begin
          w_resp_next  = bus.BRESP;
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_RD_AR: begin
        if (bus.ARREADY) begin
          w_arvalid_next = 1'b0;
          w_state_next   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (bus.RVALID) begin
          w_rdata_next = bus.RDATA;
          w_resp_next  = RESP_OKAY;
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // A genuine response arriving on the expiry cycle still wins over the watchdog.
    if (w_expired && w_busy && (w_state_next != ST_IDLE)) begin
      w_state_next   = ST_IDLE;
      w_awvalid_next = 1'b0;
      w_wvalid_next  = 1'b0;
      w_arvalid_next = 1'b0;
      w_resp_next    = RESP_DECERR;
      w_done_next    = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state   <= ST_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
    end else begin
      r_state   <= w_state_next;
      r_awvalid <= w_awvalid_next;
      r_wvalid  <= w_wvalid_next;
      r_arvalid <= w_arvalid_next;
      r_aw_done <= w_aw_done_next;
      r_w_done  <= w_w_done_next;
      r_done    <= w_done_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_rdata   <= w_rdata_next;
      r_resp    <= w_resp_next;
    end
  end

  assign ready       = (r_state == ST_IDLE);
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign resp        = r_resp;
  assign bus.AWADDR  = r_addr;
  assign bus.ARADDR  = r_addr;
  assign bus.WDATA   = r_wdata;
  assign bus.AWVALID = r_awvalid;
  assign bus.WVALID  = r_wvalid;
  assign bus.ARVALID = r_arvalid;
  assign bus.BREADY  = (r_state == ST_WR_B);
  assign bus.RREADY  = (r_state == ST_RD_R);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a 4-register slave model with adjustable READY delays.
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 256;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        transfer;
  logic        cmd_write;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  resp;

  int checks = 0;
  int failures = 0;
  int lat;
  int d0, a0, w0;

  // slave model knobs and state
  int          aw_lat, w_lat, ar_lat;
  bit          r_en;
  logic [1:0]  b_resp_cfg;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        s_have_aw, s_have_w, s_bvalid, s_rvalid;
  logic [3:0]  s_awaddr;
  logic [31:0] s_wdata, s_rdata;
  logic [31:0] regs [4];
  logic        aw_hs, w_hs, ar_hs;

  int awv_total = 0, wv_total = 0, done_total = 0;
  logic [31:0] wd [4];

  always #5 clk = ~clk;

  axi4_lite_master_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  axi4_lite_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .ACLK     (clk),
    .ARESETn  (rstn),
    .transfer (transfer),
    .write    (cmd_write),
    .addr     (addr_i),
    .wdata    (wdata_i),
    .ready    (ready),
    .done     (done),
    .rdata    (rdata),
    .resp     (resp),
    .bus      (bus)
  );

  assign bus.AWREADY = (aw_cnt >= aw_lat);
  assign bus.WREADY  = (w_cnt >= w_lat);
  assign bus.ARREADY = (ar_cnt >= ar_lat);
  assign bus.BVALID  = s_bvalid;
  assign bus.BRESP   = s_bvalid ? b_resp_cfg : 2'b00;
  assign bus.RVALID  = s_rvalid;
  assign bus.RDATA   = s_rdata;
  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      s_have_aw <= 1'b0; s_have_w <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_rdata <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= 0; s_have_aw <= 1'b1; s_awaddr <= bus.AWADDR;
      end else if (bus.AWVALID) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_cnt <= 0; s_have_w <= 1'b1; s_wdata <= bus.WDATA;
      end else if (bus.WVALID) begin
        w_cnt <= w_cnt + 1;
      end
      if (bus.BVALID && bus.BREADY) s_bvalid <= 1'b0;
      if ((s_have_aw || aw_hs) && (s_have_w || w_hs)) begin
        regs[aw_hs ? bus.AWADDR[3:2] : s_awaddr[3:2]] <= w_hs ? bus.WDATA : s_wdata;
        s_have_aw <= 1'b0; s_have_w <= 1'b0; s_bvalid <= 1'b1;
      end
      if (ar_hs) begin
        ar_cnt <= 0;
        if (r_en) begin
          s_rvalid <= 1'b1; s_rdata <= regs[bus.ARADDR[3:2]];
        end
      end else if (bus.ARVALID) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (bus.RVALID && bus.RREADY) s_rvalid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.AWVALID) awv_total <= awv_total + 1;
    if (bus.WVALID)  wv_total  <= wv_total + 1;
    if (done)        done_total <= done_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic w, input logic [3:0] a, input logic [31:0] d);
    transfer = 1'b1; cmd_write = w; addr_i = a; wdata_i = d;
  endtask

  // Latency = number of falling edges after the accepting rising edge until done is seen.
  task automatic wait_done(input int max_cyc, output int l);
    l = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        transfer = 1'b0; cmd_write = 1'b0; addr_i = '0; wdata_i = '0;
      end
      if (done === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    aw_lat = 1; w_lat = 0; ar_lat = 1; r_en = 1'b1; b_resp_cfg = RESP_OKAY;
    transfer = 1'b0; cmd_write = 1'b0; addr_i = '0; wdata_i = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_awvalid", bus.AWVALID, 0);
    check("rst_wvalid", bus.WVALID, 0);
    check("rst_arvalid", bus.ARVALID, 0);
    check("rst_bready", bus.BREADY, 0);
    check("rst_rready", bus.RREADY, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", resp, 0);
    check("rst_awaddr", bus.AWADDR, 0);
    check("rst_wdata", bus.WDATA, 0);
    rstn = 1'b1;
    @(negedge clk);

    // team slave: write then read back 0x4
    d0 = done_total;
    start_cmd(1'b1, 4'h4, 32'hDEAD_BEEF);
    wait_done(20, lat);
    check("wr_team_lat", lat, 4);
    check("wr_team_resp", resp, 2'b00);
    check("wr_team_ready", ready, 1);
    start_cmd(1'b0, 4'h4, 32'h0);
    wait_done(20, lat);
    check("rd_team_lat", lat, 4);
    check("rd_team_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_team_resp", resp, 2'b00);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("team_done_count", done_total - d0, 2);

    // zero-wait slave
    aw_lat = 0; ar_lat = 0;
    start_cmd(1'b1, 4'h8, 32'h1234_5678);
    wait_done(20, lat);
    check("wr_zw_lat", lat, 3);
    start_cmd(1'b0, 4'h8, 32'h0);
    wait_done(20, lat);
    check("rd_zw_lat", lat, 3);
    check("rd_zw_rdata", rdata, 32'h1234_5678);

    // AWREADY always high, WREADY delayed, SLVERR response
    @(negedge clk);
    w_lat = 4; b_resp_cfg = RESP_SLVERR;
    a0 = awv_total; w0 = wv_total; d0 = done_total;
    start_cmd(1'b1, 4'hC, 32'hA5A5_0F0F);
    wait_done(20, lat);
    check("wdly_lat", lat, 7);
    check("wdly_resp", resp, 2'b10);
    @(negedge clk);
    check("wdly_awvalid_cycles", awv_total - a0, 1);
    check("wdly_wvalid_cycles", wv_total - w0, 5);
    check("wdly_done_count", done_total - d0, 1);

    // transfer while busy is ignored
    w_lat = 0; aw_lat = 1; ar_lat = 1; b_resp_cfg = RESP_OKAY;
    d0 = done_total; a0 = awv_total;
    start_cmd(1'b0, 4'h8, 32'h0);
    @(negedge clk);
    transfer = 1'b0;
    @(negedge clk);
    check("busy_ready_low", ready, 0);
    start_cmd(1'b1, 4'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    transfer = 1'b0; cmd_write = 1'b0; addr_i = '0; wdata_i = '0;
    check("ign_no_early_done", done, 0);
    @(negedge clk);
    check("ign_done", done, 1);
    check("ign_ready_with_done", ready, 1);
    check("ign_rdata", rdata, 32'h1234_5678);
    repeat (4) @(negedge clk);
    check("ign_done_count", done_total - d0, 1);
    check("ign_no_write", awv_total - a0, 0);

    // reset while waiting in WR_B
    start_cmd(1'b1, 4'h0, 32'h5555_AAAA);
    @(negedge clk);
    transfer = 1'b0; cmd_write = 1'b0; addr_i = '0; wdata_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("wrb_bready", bus.BREADY, 1);
    rstn = 1'b0;
    d0 = done_total;
    @(negedge clk);
    check("mid_rst_awvalid", bus.AWVALID, 0);
    check("mid_rst_wvalid", bus.WVALID, 0);
    check("mid_rst_arvalid", bus.ARVALID, 0);
    check("mid_rst_bready", bus.BREADY, 0);
    check("mid_rst_rready", bus.RREADY, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_resp", resp, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_total - d0, 0);

    // four back-to-back writes, then back-to-back reads
    wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0004; wd[2] = 32'h3333_0008; wd[3] = 32'h4444_000C;
    start_cmd(1'b1, 4'h0, wd[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(20, lat);
      check("b2b_wr_lat", lat, 4);
      check("b2b_wr_ready", ready, 1);
      if (i < 3) start_cmd(1'b1, 4'((i + 1) * 4), wd[i + 1]);
      else       start_cmd(1'b0, 4'h0, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      wait_done(20, lat);
      check("b2b_rd_lat", lat, 4);
      check("b2b_rd_data", rdata, wd[i]);
      if (i < 3) start_cmd(1'b0, 4'((i + 1) * 4), 32'h0);
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    // read whose data never arrives
    r_en = 1'b0;
    start_cmd(1'b0, 4'h4, 32'h0);
    wait_done(40, lat);
    check("to_lat", lat, 17);
    check("to_resp", resp, RESP_DECERR);
    check("to_rdata_kept", rdata, wd[3]);
    @(negedge clk);
    check("to_rready_low", bus.RREADY, 0);
    check("to_done_low", done, 0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
